voice_matcher: RTL and testbench
================================

# voice_matcher

Parametrised successor to the voice-command matcher. It captures a fixed-length utterance of packed PDM sample words into a capture RAM. It then scores the capture word-by-word against NUM_DIRS template RAMs and emits the best-matching direction, with an explicit hit/no-hit decision. It sits between the PDM sampler and the game input logic; per-template scores are exported for debug.

## Interface

Parameters:
- NUM_DIRS, 4, number of template RAMs / directions (2..8)
- LANES, 4, samples packed per word
- SAMPLE_W, 8, bits per sample; WORD_W = LANES*SAMPLE_W
- ADDR_W, 12, RAM address width
- CHUNKS, 2830, words per utterance (1..2**ADDR_W-1)
- TOL, 15, max per-lane absolute difference counted as lane match
- THRESH, 3, min matching lanes for a word to score (1..LANES)
- CNT_W, 12, score counter width
- MARGIN, 1, required lead of best score over second best (0 = any unique max)
- DEFAULT_DIR, 1, direction output on no-hit/reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin capture (honoured in IDLE only)
- compare_en  in  1  run compare after capture; sampled on last capture write
- abort  in  1  return to IDLE from any state
- smp_valid  in  1  sample word available this cycle
- smp_data  in  WORD_W  packed sample word, lane 0 in LSBs
- ram_wr  out  1  capture RAM write enable
- ram_addr  out  ADDR_W  shared address to capture and template RAMs
- ram_wdata  out  WORD_W  capture write data (= smp_data)
- cap_rdata  in  WORD_W  capture RAM read data, 1-cycle read latency
- tmpl_rdata  in  NUM_DIRS*WORD_W  template read data, template i at slice i, 1-cycle latency
- match  out  $clog2(NUM_DIRS)  decided direction
- match_hit  out  1  decision had a qualified winner
- done  out  1  one-cycle pulse, decision updated
- busy  out  1  state != IDLE
- score  out  NUM_DIRS*CNT_W  per-template scores, held until next start

## Operation

- FSM: IDLE, RECORD, COMPARE, DECIDE.
- IDLE: start=1 → RECORD; address counter and all scores clear.
- RECORD:
  - ram_wr = smp_valid (combinational), ram_addr = counter, ram_wdata = smp_data.
  - Counter increments per write.
  - On the write with address CHUNKS-1: go to COMPARE if compare_en=1 that cycle, else IDLE (no done). Counter clears either way.
  - smp_valid outside RECORD is ignored; ram_wr=0.
- COMPARE:
  - ram_addr steps 0..CHUNKS-1, one per cycle.
  - Data for address k is evaluated in the following cycle.
  - Per template i, lane l: lane match if |cap[l]-tmpl_i[l]| <= TOL, unsigned, computed at SAMPLE_W+1 bits.
  - Word scores for template i if its matching-lane count >= THRESH; score[i] increments.
  - Scores saturate at 2**CNT_W-1.
  - After the drain cycle for address CHUNKS-1 → DECIDE.
- DECIDE:
  - best = unique maximum score.
  - Hit iff best exists and best - second_best >= MARGIN. With MARGIN=0, a unique max is still required.
  - Hit: match=index, match_hit=1. Otherwise: match=DEFAULT_DIR, match_hit=0.
  - Next state IDLE.
- abort: any state → IDLE next cycle. Scores, match and match_hit keep their current values; no done. abort has priority over start and completion.

## Timing

- Reset values:
  - state IDLE, busy=0, ram_wr=0, ram_addr=0, done=0
  - match=DEFAULT_DIR, match_hit=0, score all 0
- start to first possible write: one cycle (RECORD entered at next edge).
- COMPARE duration: CHUNKS+1 cycles; DECIDE: 1 cycle.
- match, match_hit and done update at the edge leaving DECIDE. done is high for exactly the first IDLE cycle.
- Last capture write to done: CHUNKS+3 cycles.
- Gaps in smp_valid stall RECORD indefinitely; no timeout.
- start asserted while busy is ignored. start in the done cycle is accepted.
- Reset mid-operation: immediate return to reset values; no RAM write occurs after rst asserts.

## Test plan

Bench overrides: CHUNKS=16, NUM_DIRS=4, TOL=15, THRESH=3, MARGIN=1.

- Reset → match=1, match_hit=0, busy=0, score=0, ram_wr=0.
- start, then 16 valid words 0x10203040 with compare_en=1; template 0 returns the same word; templates 1-3 return 0x90A0B0C0 → score={16,0,0,0}, match=0, match_hit=1, done 19 cycles after last write.
- Template 2 lanes differ by 15,15,15,16 (3 lanes in TOL); others differ by 16 in all lanes → score[2]=16, match=2, hit=1. Change one more lane to 16 → score[2]=0, match=1, hit=0.
- Templates 0 and 3 both identical to capture → tie 16/16, match=1, match_hit=0. Then capture 16 words where template 3 differs by 40 in all lanes on one word → scores 16/15, match=0, hit=1.
- compare_en=0 on last write → no done, busy drops next cycle, match unchanged. smp_valid with 3-cycle gaps → exactly 16 writes, addresses 0..15 in order.
- abort in COMPARE at address 5 → IDLE next cycle, no done. rst during RECORD at address 7 → ram_wr=0 immediately, all reset values restored.

Source files
------------

// File: rtl/voice_matcher.sv
// voice_matcher: captures a fixed-length utterance of packed sample words into
// an external capture RAM, scores it word-by-word against NUM_DIRS template
// RAMs and reports the best-matching direction with a hit/no-hit decision.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start; last decision and scores held
// S_RECORD  | writing valid sample words to capture RAM at addresses 0..CHUNKS-1
// S_COMPARE | issuing addresses 0..CHUNKS-1, then one drain cycle for the last word
// S_DECIDE  | scores final; decision registered at the edge leaving this state
module voice_matcher #(
    parameter int NUM_DIRS    = 4,
    parameter int LANES       = 4,
    parameter int SAMPLE_W    = 8,
    parameter int ADDR_W      = 12,
    parameter int CHUNKS      = 2830,
    parameter int TOL         = 15,
    parameter int THRESH      = 3,
    parameter int CNT_W       = 12,
    parameter int MARGIN      = 1,
    parameter int DEFAULT_DIR = 1,
    localparam int WORD_W     = LANES * SAMPLE_W,
    localparam int DIR_W      = $clog2(NUM_DIRS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       compare_en,
    input  logic                       abort,
    input  logic                       smp_valid,
    input  logic [WORD_W-1:0]          smp_data,
    output logic                       ram_wr,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [WORD_W-1:0]          ram_wdata,
    input  logic [WORD_W-1:0]          cap_rdata,
    input  logic [NUM_DIRS*WORD_W-1:0] tmpl_rdata,
    output logic [DIR_W-1:0]           match,
    output logic                       match_hit,
    output logic                       done,
    output logic                       busy,
    output logic [NUM_DIRS*CNT_W-1:0]  score
);

    localparam int LCNT_W = $clog2(LANES + 1);

    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(CHUNKS - 1);
    localparam logic [SAMPLE_W:0]   TOL_V     = (SAMPLE_W + 1)'(TOL);
    localparam logic [LCNT_W-1:0]   THRESH_V  = LCNT_W'(THRESH);
    localparam logic [CNT_W:0]      MARGIN_V  = (CNT_W + 1)'(MARGIN);
    localparam logic [DIR_W-1:0]    DEF_DIR   = DIR_W'(DEFAULT_DIR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECORD,
        S_COMPARE,
        S_DECIDE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_cnt;
    logic              drain;       // COMPARE has issued its last address
    logic              eval_valid;  // RAM read data this cycle belongs to an issued address
    logic [CNT_W-1:0]  score_q [NUM_DIRS];

    logic [NUM_DIRS-1:0] word_hit;
    logic [LCNT_W-1:0]   lane_cnt;
    logic [SAMPLE_W:0]   lane_a;
    logic [SAMPLE_W:0]   lane_b;
    logic [SAMPLE_W:0]   lane_diff;

    logic [CNT_W-1:0] best_val;
    logic [CNT_W-1:0] second_val;
    logic [CNT_W-1:0] lead;
    logic [DIR_W-1:0] best_idx;
    logic             tie;
    logic             hit_c;

    logic rec_last_wr;
    logic cmp_last_issue;

    assign ram_wdata      = smp_data;
    assign rec_last_wr    = (state_q == S_RECORD) && smp_valid && (addr_cnt == LAST_ADDR);
    assign cmp_last_issue = (state_q == S_COMPARE) && !drain && (addr_cnt == LAST_ADDR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and RAM port control; abort overrides every transition.
    always_comb begin
        state_d  = state_q;
        ram_wr   = 1'b0;
        ram_addr = '0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RECORD;
            end
            S_RECORD: begin
                ram_wr   = smp_valid;
                ram_addr = addr_cnt;
                if (rec_last_wr) state_d = compare_en ? S_COMPARE : S_IDLE;
            end
            S_COMPARE: begin
                ram_addr = addr_cnt;
                if (drain) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Shared address counter plus the one-cycle read pipeline flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt   <= '0;
            drain      <= 1'b0;
            eval_valid <= 1'b0;
        end else if (abort) begin
            addr_cnt   <= '0;
            drain      <= 1'b0;
            eval_valid <= 1'b0;
        end else begin
            eval_valid <= (state_q == S_COMPARE) && !drain;
            drain      <= cmp_last_issue;
            case (state_q)
                S_RECORD: begin
                    if (smp_valid) addr_cnt <= rec_last_wr ? '0 : addr_cnt + ADDR_W'(1);
                end
                S_COMPARE: begin
                    if (!drain) addr_cnt <= cmp_last_issue ? '0 : addr_cnt + ADDR_W'(1);
                end
                default: begin
                    addr_cnt <= '0;
                end
            endcase
        end
    end

    // Per-template lane tolerance test and word qualification on the read data.
    always_comb begin
        word_hit  = '0;
        lane_cnt  = '0;
        lane_a    = '0;
        lane_b    = '0;
        lane_diff = '0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            lane_cnt = '0;
            for (int l = 0; l < LANES; l++) begin
                lane_a    = {1'b0, cap_rdata[l*SAMPLE_W +: SAMPLE_W]};
                lane_b    = {1'b0, tmpl_rdata[d*WORD_W + l*SAMPLE_W +: SAMPLE_W]};
                lane_diff = (lane_a >= lane_b) ? (lane_a - lane_b) : (lane_b - lane_a);
                if (lane_diff <= TOL_V) lane_cnt = lane_cnt + LCNT_W'(1);
            end
            word_hit[d] = (lane_cnt >= THRESH_V);
        end
    end

    // Score counters: cleared on an accepted start, saturating increments while comparing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NUM_DIRS; d++) score_q[d] <= '0;
        end else if (!abort) begin
            if (state_q == S_IDLE && start) begin
                for (int d = 0; d < NUM_DIRS; d++) score_q[d] <= '0;
            end else if (eval_valid) begin
                for (int d = 0; d < NUM_DIRS; d++) begin
                    if (word_hit[d] && (score_q[d] != '1)) score_q[d] <= score_q[d] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the score array onto the debug port.
    always_comb begin
        score = '0;
        for (int d = 0; d < NUM_DIRS; d++) score[d*CNT_W +: CNT_W] = score_q[d];
    end

    // Winner search: unique maximum and its lead over the runner-up.
    always_comb begin
        best_val   = score_q[0];
        best_idx   = '0;
        second_val = '0;
        tie        = 1'b0;
        for (int d = 1; d < NUM_DIRS; d++) begin
            if (score_q[d] > best_val) begin
                best_val = score_q[d];
                best_idx = DIR_W'(d);
            end
        end
        for (int d = 0; d < NUM_DIRS; d++) begin
            if (DIR_W'(d) != best_idx) begin
                if (score_q[d] == best_val) tie = 1'b1;
                if (score_q[d] > second_val) second_val = score_q[d];
            end
        end
        lead  = best_val - second_val;
        hit_c = !tie && ({1'b0, lead} >= MARGIN_V);
    end

    // Decision outputs and the done pulse, updated only when DECIDE completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match     <= DEF_DIR;
            match_hit <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state_q == S_DECIDE) && !abort;
            if (state_q == S_DECIDE && !abort) begin
                match     <= hit_c ? best_idx : DEF_DIR;
                match_hit <= hit_c;
            end
        end
    end

endmodule

// File: tb/tb_voice_matcher.sv
// Directed bench for voice_matcher with a behavioural capture RAM and template
// RAMs (1-cycle read latency), CHUNKS=16 and four templates.
module tb_voice_matcher;

    localparam int NUM_DIRS = 4;
    localparam int WORD_W   = 32;
    localparam int ADDR_W   = 12;
    localparam int CNT_W    = 12;
    localparam int CHUNKS   = 16;

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic                       compare_en;
    logic                       abort;
    logic                       smp_valid;
    logic [WORD_W-1:0]          smp_data;
    logic                       ram_wr;
    logic [ADDR_W-1:0]          ram_addr;
    logic [WORD_W-1:0]          ram_wdata;
    logic [WORD_W-1:0]          cap_rdata;
    logic [NUM_DIRS*WORD_W-1:0] tmpl_rdata;
    logic [1:0]                 match;
    logic                       match_hit;
    logic                       done;
    logic                       busy;
    logic [NUM_DIRS*CNT_W-1:0]  score;

    logic [WORD_W-1:0] cap_mem   [CHUNKS];
    logic [WORD_W-1:0] cap_words [CHUNKS];
    logic [WORD_W-1:0] tmpl_mem  [NUM_DIRS][CHUNKS];
    int                wr_cnt;

    int checks;
    int failures;

    voice_matcher #(
        .NUM_DIRS(NUM_DIRS), .LANES(4), .SAMPLE_W(8), .ADDR_W(ADDR_W), .CHUNKS(CHUNKS),
        .TOL(15), .THRESH(3), .CNT_W(CNT_W), .MARGIN(1), .DEFAULT_DIR(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .compare_en(compare_en), .abort(abort),
        .smp_valid(smp_valid), .smp_data(smp_data), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .cap_rdata(cap_rdata), .tmpl_rdata(tmpl_rdata),
        .match(match), .match_hit(match_hit), .done(done), .busy(busy), .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAMs shared by one address bus.
    always @(posedge clk) begin
        cap_rdata <= cap_mem[ram_addr[3:0]];
        for (int d = 0; d < NUM_DIRS; d++) tmpl_rdata[d*WORD_W +: WORD_W] <= tmpl_mem[d][ram_addr[3:0]];
        if (ram_wr) begin
            cap_mem[ram_addr[3:0]] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic fill(input logic [31:0] c, input logic [31:0] t0, input logic [31:0] t1,
                        input logic [31:0] t2, input logic [31:0] t3);
        for (int i = 0; i < CHUNKS; i++) begin
            cap_words[i]   = c;
            tmpl_mem[0][i] = t0;
            tmpl_mem[1][i] = t1;
            tmpl_mem[2][i] = t2;
            tmpl_mem[3][i] = t3;
        end
    endtask

    // Feeds CHUNKS words; returns at the negedge after the last write edge.
    task automatic capture(input bit do_start, input bit cen, input int gap,
                           input bit start_noise, output int bad);
        bad = 0;
        if (do_start) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        for (int i = 0; i < CHUNKS; i++) begin
            for (int g = 0; g < gap; g++) begin
                smp_valid = 1'b0;
                start     = start_noise;
                #1;
                if (ram_wr !== 1'b0) bad++;
                @(negedge clk);
            end
            start      = 1'b0;
            smp_valid  = 1'b1;
            smp_data   = cap_words[i];
            compare_en = (i == CHUNKS - 1) ? cen : 1'b0;
            #1;
            if (ram_wr !== 1'b1 || ram_addr !== ADDR_W'(i) || ram_wdata !== cap_words[i]) bad++;
            @(negedge clk);
        end
        smp_valid  = 1'b0;
        compare_en = 1'b0;
    endtask

    // Counts cycles from the last write cycle until done is seen (capped).
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks += 6;
        if (match !== 2'd1)     begin failures++; $display("FAIL reset_match got=%0d exp=1", match); end
        if (match_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0b exp=0", match_hit); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (score !== '0)       begin failures++; $display("FAIL reset_score got=%h exp=0", score); end
        if (ram_wr !== 1'b0)    begin failures++; $display("FAIL reset_ram_wr got=%0b exp=0", ram_wr); end
        if (done !== 1'b0 || ram_addr !== '0) begin
            failures++; $display("FAIL reset_done_addr got=%0b/%0d exp=0/0", done, ram_addr);
        end
    endtask

    task automatic test_exact;
        int bad, lat;
        fill(32'h10203040, 32'h10203040, 32'h90A0B0C0, 32'h90A0B0C0, 32'h90A0B0C0);
        capture(1'b1, 1'b1, 0, 1'b0, bad);
        wait_done(lat);
        checks += 6;
        if (bad != 0)  begin failures++; $display("FAIL exact_writes bad=%0d exp=0", bad); end
        if (lat != 19) begin failures++; $display("FAIL exact_latency got=%0d exp=19", lat); end
        if (score !== {12'd0, 12'd0, 12'd0, 12'd16}) begin
            failures++; $display("FAIL exact_score got=%h exp=%h", score, {12'd0, 12'd0, 12'd0, 12'd16});
        end
        if (match !== 2'd0)     begin failures++; $display("FAIL exact_match got=%0d exp=0", match); end
        if (match_hit !== 1'b1) begin failures++; $display("FAIL exact_hit got=%0b exp=1", match_hit); end
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL exact_done_pulse done=%0b busy=%0b exp=0/0", done, busy);
        end
    endtask

    task automatic test_tolerance;
        int bad, lat;
        // template 2 lanes: -15, +15, -15, +16 ; others off by 16 in every lane
        fill(32'h10203040, 32'h00102030, 32'h20304050, 32'h20113F31, 32'h20304050);
        capture(1'b1, 1'b1, 0, 1'b0, bad);
        wait_done(lat);
        checks += 4;
        if (bad != 0 || lat != 19) begin failures++; $display("FAIL tol_run bad=%0d lat=%0d exp=0/19", bad, lat); end
        if (score !== {12'd0, 12'd16, 12'd0, 12'd0}) begin
            failures++; $display("FAIL tol_score got=%h exp=%h", score, {12'd0, 12'd16, 12'd0, 12'd0});
        end
        if (match !== 2'd2)     begin failures++; $display("FAIL tol_match got=%0d exp=2", match); end
        if (match_hit !== 1'b1) begin failures++; $display("FAIL tol_hit got=%0b exp=1", match_hit); end
        // lane 1 moved to +16: only two lanes within tolerance
        fill(32'h10203040, 32'h00102030, 32'h20304050, 32'h20114031, 32'h20304050);
        capture(1'b1, 1'b1, 0, 1'b0, bad);
        wait_done(lat);
        checks += 4;
        if (bad != 0 || lat != 19) begin failures++; $display("FAIL tol2_run bad=%0d lat=%0d exp=0/19", bad, lat); end
        if (score !== '0)       begin failures++; $display("FAIL tol2_score got=%h exp=0", score); end
        if (match !== 2'd1)     begin failures++; $display("FAIL tol2_match got=%0d exp=1", match); end
        if (match_hit !== 1'b0) begin failures++; $display("FAIL tol2_hit got=%0b exp=0", match_hit); end
    endtask

    task automatic test_tie_and_back_to_back;
        int bad, lat;
        fill(32'h10203040, 32'h10203040, 32'h90A0B0C0, 32'h90A0B0C0, 32'h10203040);
        capture(1'b1, 1'b1, 0, 1'b0, bad);
        wait_done(lat);
        checks += 4;
        if (bad != 0 || lat != 19) begin failures++; $display("FAIL tie_run bad=%0d lat=%0d exp=0/19", bad, lat); end
        if (score !== {12'd16, 12'd0, 12'd0, 12'd16}) begin
            failures++; $display("FAIL tie_score got=%h exp=%h", score, {12'd16, 12'd0, 12'd0, 12'd16});
        end
        if (match !== 2'd1)     begin failures++; $display("FAIL tie_match got=%0d exp=1", match); end
        if (match_hit !== 1'b0) begin failures++; $display("FAIL tie_hit got=%0b exp=0", match_hit); end
        // start in the done cycle; template 3 off by 40 on word 7
        tmpl_mem[3][7] = 32'h38485868;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_start busy=%0b exp=1", busy); end
        capture(1'b0, 1'b1, 0, 1'b0, bad);
        wait_done(lat);
        checks += 4;
        if (bad != 0 || lat != 19) begin failures++; $display("FAIL b2b_run bad=%0d lat=%0d exp=0/19", bad, lat); end
        if (score !== {12'd15, 12'd0, 12'd0, 12'd16}) begin
            failures++; $display("FAIL b2b_score got=%h exp=%h", score, {12'd15, 12'd0, 12'd0, 12'd16});
        end
        if (match !== 2'd0)     begin failures++; $display("FAIL b2b_match got=%0d exp=0", match); end
        if (match_hit !== 1'b1) begin failures++; $display("FAIL b2b_hit got=%0b exp=1", match_hit); end
    endtask

    task automatic test_no_compare_gaps;
        int bad, w0, seen;
        fill(32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344);
        for (int i = 0; i < CHUNKS; i++) cap_words[i] = 32'h0A0B0C00 + 32'(i);
        w0 = wr_cnt;
        capture(1'b1, 1'b0, 3, 1'b1, bad);
        checks += 3;
        if (bad != 0)          begin failures++; $display("FAIL gap_writes bad=%0d exp=0", bad); end
        if (wr_cnt - w0 != 16) begin failures++; $display("FAIL gap_wr_count got=%0d exp=16", wr_cnt - w0); end
        if (busy !== 1'b0)     begin failures++; $display("FAIL gap_busy got=%0b exp=0", busy); end
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        checks += 4;
        if (seen != 0)          begin failures++; $display("FAIL gap_no_done got=%0d exp=0", seen); end
        if (match !== 2'd0)     begin failures++; $display("FAIL gap_match got=%0d exp=0", match); end
        if (match_hit !== 1'b1) begin failures++; $display("FAIL gap_hit got=%0b exp=1", match_hit); end
        if (score !== '0)       begin failures++; $display("FAIL gap_score got=%h exp=0", score); end
        checks++;
        if (cap_mem[9] !== 32'h0A0B0C09) begin failures++; $display("FAIL gap_ram_word9 got=%h exp=0a0b0c09", cap_mem[9]); end
    endtask

    task automatic test_abort;
        int bad, n, seen;
        fill(32'h10203040, 32'h10203040, 32'h90A0B0C0, 32'h90A0B0C0, 32'h90A0B0C0);
        capture(1'b1, 1'b1, 0, 1'b0, bad);
        n = 0;
        while (ram_addr !== 12'd5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (bad != 0) begin failures++; $display("FAIL abort_writes bad=%0d exp=0", bad); end
        if (n != 5)   begin failures++; $display("FAIL abort_reach_addr5 cycles=%0d exp=5", n); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        if (score !== {12'd0, 12'd0, 12'd0, 12'd4}) begin
            failures++; $display("FAIL abort_score got=%h exp=%h", score, {12'd0, 12'd0, 12'd0, 12'd4});
        end
        if (match !== 2'd0)     begin failures++; $display("FAIL abort_match got=%0d exp=0", match); end
        if (match_hit !== 1'b1) begin failures++; $display("FAIL abort_hit got=%0b exp=1", match_hit); end
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid_record;
        int w0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            smp_valid = 1'b1;
            smp_data  = 32'hCAFE0000 + 32'(i);
            @(negedge clk);
        end
        smp_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (ram_wr !== 1'b1 || ram_addr !== 12'd7) begin
            failures++; $display("FAIL rstmid_pre wr=%0b addr=%0d exp=1/7", ram_wr, ram_addr);
        end
        w0  = wr_cnt;
        rst = 1'b1;
        #1;
        checks += 4;
        if (ram_wr !== 1'b0)   begin failures++; $display("FAIL rstmid_ram_wr got=%0b exp=0", ram_wr); end
        if (busy !== 1'b0 || ram_addr !== '0 || done !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl busy=%0b addr=%0d done=%0b exp=0/0/0", busy, ram_addr, done);
        end
        if (match !== 2'd1 || match_hit !== 1'b0) begin
            failures++; $display("FAIL rstmid_decision match=%0d hit=%0b exp=1/0", match, match_hit);
        end
        if (score !== '0)      begin failures++; $display("FAIL rstmid_score got=%h exp=0", score); end
        @(negedge clk);
        checks++;
        if (wr_cnt != w0 || cap_mem[7] === 32'hDEADBEEF) begin
            failures++; $display("FAIL rstmid_no_write writes=%0d exp=%0d", wr_cnt, w0);
        end
        smp_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        wr_cnt     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        compare_en = 1'b0;
        abort      = 1'b0;
        smp_valid  = 1'b0;
        smp_data   = '0;
        for (int i = 0; i < CHUNKS; i++) cap_mem[i] = '0;
        fill('0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_exact;
        test_tolerance;
        test_tie_and_back_to_back;
        test_no_compare_gaps;
        test_abort;
        test_reset_mid_record;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
